// File: rtl/fir_tap_sequencer.sv
// Single-MAC symmetric FIR sequencer: walks coef_addr 1..HALF_TAPS..1, one mul+add per tap.
// 2*OP_LAT+3 cycles per tap when unstalled; stalls on missing sample or busy multiplier/adder.
module fir_tap_sequencer #(
  parameter int HALF_TAPS = 73,
  parameter int OP_LAT    = 7,
  parameter int AW        = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stop,
  input  logic          sample_valid,
  input  logic          mul_busy,
  input  logic          add_busy,
  output logic          sample_req,
  output logic [AW-1:0] coef_addr,
  output logic          mul_start,
  output logic          add_start,
  output logic          acc_clr,
  output logic [AW-1:0] tap_idx,
  output logic          busy,
  output logic          done,
  output logic          aborted
);

  localparam int CW = $clog2(OP_LAT + 1);
  localparam logic [AW-1:0] LAST_TAP  = AW'(2 * HALF_TAPS - 1);
  localparam logic [CW-1:0] WAIT_LOAD = CW'(OP_LAT - 1);

  typedef enum logic [2:0] {
    IDLE, CLEAR, FETCH, MUL, MUL_WAIT, ACC, ACC_WAIT, DONE
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [AW-1:0] tap_nxt, addr_nxt;
  logic          cnt_load, tap_adv, run_start;

  assign busy      = (state != IDLE);
  assign run_start = (state == IDLE) && start && !stop;

  // Second half of the walk mirrors the first, so the centre address repeats.
  always_comb begin
    tap_nxt = tap_idx + 1'b1;
    if (tap_nxt < AW'(HALF_TAPS)) addr_nxt = tap_nxt + 1'b1;
    else                          addr_nxt = AW'(2 * HALF_TAPS) - tap_nxt;
  end

  always_comb begin
    state_nxt  = state;
    sample_req = 1'b0;
    mul_start  = 1'b0;
    add_start  = 1'b0;
    acc_clr    = 1'b0;
    done       = 1'b0;
    cnt_load   = 1'b0;
    tap_adv    = 1'b0;
    case (state)
      IDLE:     if (run_start) state_nxt = CLEAR;
      CLEAR: begin
        acc_clr   = 1'b1;
        state_nxt = FETCH;
      end
      FETCH: begin
        sample_req = 1'b1;
        if (sample_valid) state_nxt = MUL;
      end
      MUL: if (!mul_busy) begin
        mul_start = 1'b1;
        cnt_load  = 1'b1;
        state_nxt = MUL_WAIT;
      end
      MUL_WAIT: if (cnt == '0) state_nxt = ACC;
      ACC: if (!add_busy) begin
        add_start = 1'b1;
        cnt_load  = 1'b1;
        state_nxt = ACC_WAIT;
      end
      ACC_WAIT: if (cnt == '0) begin
        if (tap_idx == LAST_TAP) begin
          state_nxt = DONE;
        end else begin
          tap_adv   = 1'b1;
          state_nxt = FETCH;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Abort suppresses every handshake in the stop cycle, including sample acceptance.
    if (stop && state != IDLE) begin
      state_nxt  = IDLE;
      sample_req = 1'b0;
      mul_start  = 1'b0;
      add_start  = 1'b0;
      done       = 1'b0;
      cnt_load   = 1'b0;
      tap_adv    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      tap_idx   <= '0;
      coef_addr <= '0;
      aborted   <= 1'b0;
    end else begin
      state   <= state_nxt;
      aborted <= stop && (state != IDLE);
      if (cnt_load)        cnt <= WAIT_LOAD;
      else if (cnt != '0)  cnt <= cnt - 1'b1;
      if (run_start) begin
        tap_idx   <= '0;
        coef_addr <= AW'(1);
      end else if (tap_adv) begin
        tap_idx   <= tap_nxt;
        coef_addr <= addr_nxt;
      end
    end
  end

endmodule
